// File: rtl/wb_port_sched_if.sv
// Writeback bundle / register-file port bundle for wb_port_sched.
//   master : upstream writeback stage (drives flush and the 3-pipe bundle,
//            observes stall and the register-file write port)
//   slave  : the scheduler itself
interface wb_port_sched_if;
  logic        flush;
  logic        w2r_wrpipe1, w2r_wrpipe2, w2r_wrpipe3;
  logic [3:0]  w2re_destpipe1, w2re_destpipe2, w2re_destpipe3;
  logic [63:0] w2re_datapipe1, w2re_datapipe2, w2re_datapipe3;
  logic        stall;
  logic        rf_wren;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        coll_drop;

  modport master (
    output flush, w2r_wrpipe1, w2r_wrpipe2, w2r_wrpipe3,
           w2re_destpipe1, w2re_destpipe2, w2re_destpipe3,
           w2re_datapipe1, w2re_datapipe2, w2re_datapipe3,
    input  stall, rf_wren, rf_waddr, rf_wdata, coll_drop
  );

  modport slave (
    input  flush, w2r_wrpipe1, w2r_wrpipe2, w2r_wrpipe3,
           w2re_destpipe1, w2re_destpipe2, w2re_destpipe3,
           w2re_datapipe1, w2re_datapipe2, w2re_datapipe3,
    output stall, rf_wren, rf_waddr, rf_wdata, coll_drop
  );
endinterface

// File: rtl/wb_port_sched.sv
// wb_port_sched: serializes up to three writeback writes per bundle onto a
// single register-file write port through three holding slots (slot n is
// fed by pipe n).
//   clock : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : wb_port_sched_if.slave -- flush, 3-pipe bundle in; stall,
//           rf_wren/rf_waddr/rf_wdata and coll_drop out

// One holding slot. Priority: reset > clear > load > retire.
module wb_port_sched_slot (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        load,
  input  logic        retire,
  input  logic        in_vld,
  input  logic [3:0]  in_dst,
  input  logic [63:0] in_dat,
  output logic        vld,
  output logic [3:0]  dst,
  output logic [63:0] dat
);
  always_ff @(posedge clock) begin
    if (!reset || clr) begin
      vld <= 1'b0;
      dst <= '0;
      dat <= '0;
    end else if (load) begin
      // a load always overwrites; any single slot still valid is the one
      // being retired on this same edge
      vld <= in_vld;
      dst <= in_dst;
      dat <= in_dat;
    end else if (retire) begin
      vld <= 1'b0;
    end
  end
endmodule

module wb_port_sched (
  input  logic            clock,
  input  logic            reset,
  wb_port_sched_if.slave  bus
);
  localparam int NUM_LANES = 3;

  logic [NUM_LANES-1:0]        in_wr, eff, slot_vld, ret_oh;
  logic [NUM_LANES-1:0][3:0]   in_dst, slot_dst;
  logic [NUM_LANES-1:0][63:0]  in_dat, slot_dat;
  logic                        accept, drop_any, coll_q;

  assign in_wr  = {bus.w2r_wrpipe3, bus.w2r_wrpipe2, bus.w2r_wrpipe1};
  assign in_dst = {bus.w2re_destpipe3, bus.w2re_destpipe2, bus.w2re_destpipe1};
  assign in_dat = {bus.w2re_datapipe3, bus.w2re_datapipe2, bus.w2re_datapipe1};

  // Same-destination resolution: a write survives only if no higher pipe
  // in the bundle writes the same register.
  always_comb begin
    eff = in_wr;
    for (int i = 0; i < NUM_LANES; i++)
      for (int j = i + 1; j < NUM_LANES; j++)
        if (in_wr[j] && in_dst[j] == in_dst[i]) eff[i] = 1'b0;
  end
  assign drop_any = |(in_wr & ~eff);

  // lowest-numbered valid slot, one-hot
  assign ret_oh    = slot_vld & (~slot_vld + 3'd1);
  // more than one valid slot <=> clearing the lowest still leaves one set
  assign bus.stall = |(slot_vld & (slot_vld - 3'd1));
  assign accept    = !bus.stall && !bus.flush;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_slot
    wb_port_sched_slot u_slot (
      .clock  (clock),
      .reset  (reset),
      .clr    (bus.flush),
      .load   (accept),
      .retire (ret_oh[l]),
      .in_vld (eff[l]),
      .in_dst (in_dst[l]),
      .in_dat (in_dat[l]),
      .vld    (slot_vld[l]),
      .dst    (slot_dst[l]),
      .dat    (slot_dat[l])
    );
  end

  always_comb begin
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (ret_oh[i]) begin
        bus.rf_waddr = slot_dst[i];
        bus.rf_wdata = slot_dat[i];
      end
    end
  end
  assign bus.rf_wren = |slot_vld;

  always_ff @(posedge clock) begin
    if (!reset || bus.flush) coll_q <= 1'b0;
    else                     coll_q <= accept && drop_any;
  end
  assign bus.coll_drop = coll_q;
endmodule

// File: tb/tb_wb_port_sched.sv
module tb_wb_port_sched;
  logic clock = 1'b0;
  logic reset;
  wb_port_sched_if bus ();

  wb_port_sched dut (.clock(clock), .reset(reset), .bus(bus.slave));

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  a;
    logic [63:0] d;
  } wr_t;

  wr_t q[$];
  bit  m_coll;
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Queue-of-pending-writes reference: one write leaves per cycle; a new
  // bundle is taken whenever at most one write is pending.
  task automatic model_edge();
    logic        wr[3];
    logic [3:0]  dst[3];
    logic [63:0] dat[3];
    bit          kill;
    wr  = '{bus.w2r_wrpipe1, bus.w2r_wrpipe2, bus.w2r_wrpipe3};
    dst = '{bus.w2re_destpipe1, bus.w2re_destpipe2, bus.w2re_destpipe3};
    dat = '{bus.w2re_datapipe1, bus.w2re_datapipe2, bus.w2re_datapipe3};
    if (!reset || bus.flush) begin
      q.delete();
      m_coll = 0;
    end else if (q.size() <= 1) begin
      q.delete();
      m_coll = 0;
      for (int n = 0; n < 3; n++) begin
        if (!wr[n]) continue;
        kill = 0;
        for (int m = n + 1; m < 3; m++)
          if (wr[m] && dst[m] == dst[n]) kill = 1;
        if (kill) m_coll = 1;
        else q.push_back('{dst[n], dat[n]});
      end
    end else begin
      void'(q.pop_front());
      m_coll = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    chk("stall",    {63'd0, bus.stall},     {63'd0, q.size() > 1});
    chk("rf_wren",  {63'd0, bus.rf_wren},   {63'd0, q.size() > 0});
    chk("rf_waddr", {60'd0, bus.rf_waddr},  q.size() ? {60'd0, q[0].a} : 64'd0);
    chk("rf_wdata", bus.rf_wdata,           q.size() ? q[0].d : 64'd0);
    chk("coll_drop",{63'd0, bus.coll_drop}, {63'd0, m_coll});
  endtask

  task automatic bundle(input logic [2:0] wr, input logic [3:0] a1, a2, a3,
                        input logic [63:0] d1, d2, d3);
    {bus.w2r_wrpipe3, bus.w2r_wrpipe2, bus.w2r_wrpipe1} = wr;
    bus.w2re_destpipe1 = a1; bus.w2re_destpipe2 = a2; bus.w2re_destpipe3 = a3;
    bus.w2re_datapipe1 = d1; bus.w2re_datapipe2 = d2; bus.w2re_datapipe3 = d3;
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    reset = 1'b0;
    bus.flush = 1'b0;
    bundle(3'b111, 4'd1, 4'd2, 4'd3, 64'h11, 64'h22, 64'h33);
    repeat (2) cycle();                       // bundle under reset ignored
    reset = 1'b1;
    bundle(3'b000, 0, 0, 0, 0, 0, 0);
    cycle();

    // three distinct writes drain in pipe order
    bundle(3'b111, 4'd1, 4'd2, 4'd3, 64'hA, 64'hB, 64'hC);
    cycle();
    bundle(3'b000, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    // pipe 3 beats pipe 1 on dest 5
    bundle(3'b101, 4'd5, 4'd9, 4'd5, 64'hA, 64'hB, 64'hC);
    cycle();
    bundle(3'b000, 0, 0, 0, 0, 0, 0);
    cycle();
    // back-to-back singles on pipe 2, dest 7
    for (int i = 0; i < 6; i++) begin
      bundle(3'b010, 0, 4'd7, 0, 0, 64'(100 + i), 0);
      cycle();
    end
    // flush mid-drain
    bundle(3'b111, 4'd0, 4'd4, 4'd8, r64(), r64(), r64());
    cycle();
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    bundle(3'b000, 0, 0, 0, 0, 0, 0);
    cycle();
    // reset mid-drain
    bundle(3'b111, 4'd1, 4'd2, 4'd3, r64(), r64(), r64());
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    bundle(3'b000, 0, 0, 0, 0, 0, 0);
    cycle();

    // random traffic; small dest range to provoke collisions
    for (int i = 0; i < 1500; i++) begin
      if (q.size() <= 1)
        bundle(3'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               4'($urandom_range(0, 3)), r64(), r64(), r64());
      bus.flush = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 49) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
